alu_issue_stage: RTL and testbench

// Upstream issue stage for the 5-bit alu. Buffers ALU requests on a valid/ready input,

---
 rtl/alu_issue_stage.sv | 163 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Issue stage in front of a combinational alu.
// Requests are buffered in a small FIFO, issued onto registered alu inputs (S1),
// and the alu result is captured into an output register (S2) with valid/ready.
// A carry register lets chained requests take CIN from the previous COUT.
module alu_issue_stage #(
  parameter int WIDTH = 5,
  parameter int SEL_W = 4,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [SEL_W-1:0] IN_OP,
  input  logic [WIDTH-1:0] IN_A,
  input  logic [WIDTH-1:0] IN_B,
  input  logic             IN_CIN,
  input  logic             IN_CHAIN,
  output logic [SEL_W-1:0] MUX_SELECT,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             CIN,
  input  logic [WIDTH-1:0] SUM,
  input  logic             COUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_SUM,
  output logic             OUT_COUT,
  output logic             OUT_ZERO
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  // FIFO storage (data only, never reset)
  logic [SEL_W-1:0] fifo_op_q    [DEPTH];
  logic [WIDTH-1:0] fifo_a_q     [DEPTH];
  logic [WIDTH-1:0] fifo_b_q     [DEPTH];
  logic             fifo_cin_q   [DEPTH];
  logic             fifo_chain_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             s1_vld_q, s1_vld_d;
  logic [SEL_W-1:0] mux_sel_q, mux_sel_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;

  logic             s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;

  logic             carry_q, carry_d;

  logic             in_ready;
  logic             push, pop, s2_load, s1_adv;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // No pop-through: a full FIFO refuses new requests even if the head leaves this cycle.
  assign in_ready = (count_q < DEPTH_C) && !RST;

  // Handshake and pipeline advance decisions
  always_comb begin
    s2_load = !s2_vld_q || OUT_READY;
    s1_adv  = s1_vld_q && s2_load;
    pop     = (count_q != '0) && (!s1_vld_q || s1_adv);
    push    = IN_VALID && in_ready;
  end

  // Write accepted requests into the FIFO
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_op_q[wr_ptr_q]    <= IN_OP;
      fifo_a_q[wr_ptr_q]     <= IN_A;
      fifo_b_q[wr_ptr_q]     <= IN_B;
      fifo_cin_q[wr_ptr_q]   <= IN_CIN;
      fifo_chain_q[wr_ptr_q] <= IN_CHAIN;
    end
  end

  // Next-state for FIFO pointers, issue regs, result regs and carry
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // S1: issue regs hold their values whenever nothing new is loaded
    s1_vld_d  = pop ? 1'b1 : (s1_adv ? 1'b0 : s1_vld_q);
    mux_sel_d = mux_sel_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    if (pop) begin
      mux_sel_d = fifo_op_q[rd_ptr_q];
      a_d       = fifo_a_q[rd_ptr_q];
      b_d       = fifo_b_q[rd_ptr_q];
      // A chained op whose predecessor is leaving S1 on this same edge takes the
      // live COUT; otherwise the predecessor's carry is already in carry_q.
      if (fifo_chain_q[rd_ptr_q]) cin_d = s1_adv ? COUT : carry_q;
      else                        cin_d = fifo_cin_q[rd_ptr_q];
    end

    // S2: capture the alu result as S1 advances
    s2_vld_d   = s2_load ? s1_vld_q : s2_vld_q;
    out_sum_d  = s1_adv ? SUM  : out_sum_q;
    out_cout_d = s1_adv ? COUT : out_cout_q;

    carry_d    = s1_adv ? COUT : carry_q;
  end

  // State registers; reset drops everything in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      s1_vld_q   <= 1'b0;
      mux_sel_q  <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      s2_vld_q   <= 1'b0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      s1_vld_q   <= s1_vld_d;
      mux_sel_q  <= mux_sel_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      s2_vld_q   <= s2_vld_d;
      out_sum_q  <= out_sum_d;
      out_cout_q <= out_cout_d;
      carry_q    <= carry_d;
    end
  end

  assign IN_READY   = in_ready;
  assign MUX_SELECT = mux_sel_q;
  assign A          = a_q;
  assign B          = b_q;
  assign CIN        = cin_q;
  assign OUT_VALID  = s2_vld_q;
  assign OUT_SUM    = out_sum_q;
  assign OUT_COUT   = out_cout_q;
  assign OUT_ZERO   = (out_sum_q == '0);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and randomized bench for alu_issue_stage with a behavioural alu stub
// ({COUT,SUM} = A+B+CIN regardless of select).
module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, in_cin, in_chain;
  logic [3:0] in_op, mux_select;
  logic [4:0] in_a, in_b, a, b, sum, out_sum;
  logic       cin, cout, out_valid, out_ready, out_cout, out_zero;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.WIDTH(5), .SEL_W(4), .DEPTH(2)) dut (
    .CLK(clk), .RST(rst),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_OP(in_op), .IN_A(in_a), .IN_B(in_b),
    .IN_CIN(in_cin), .IN_CHAIN(in_chain),
    .MUX_SELECT(mux_select), .A(a), .B(b), .CIN(cin), .SUM(sum), .COUT(cout),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_SUM(out_sum), .OUT_COUT(out_cout),
    .OUT_ZERO(out_zero)
  );

  // alu stub
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {5'd0, cin};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] aa, input logic [4:0] bb,
                       input logic c, input logic ch);
    in_valid = v; in_op = op; in_a = aa; in_b = bb; in_cin = c; in_chain = ch;
  endtask

  task automatic test_reset;
    rst = 1'b1; out_ready = 1'b1; drive(1'b0, 4'h0, 5'h0, 5'h0, 1'b0, 1'b0);
    tick; tick;
    vec++;
    if ({mux_select, a, b, cin, out_valid, out_sum, out_cout, out_zero, in_ready} !==
        {4'h0, 5'h00, 5'h00, 1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL reset_outputs got sel=%h a=%h b=%h cin=%b ov=%b sum=%h cout=%b zero=%b rdy=%b",
               mux_select, a, b, cin, out_valid, out_sum, out_cout, out_zero, in_ready);
    end
    rst = 1'b0;
    #1;
    vec++;
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
    tick;
  endtask

  task automatic test_single;
    out_ready = 1'b1;
    drive(1'b1, 4'h0, 5'h08, 5'h11, 1'b0, 1'b0);
    tick;                                    // edge N: accepted
    drive(1'b0, 4'h0, 5'h00, 5'h00, 1'b0, 1'b0);
    vec++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL single_n_valid got %b want 0", out_valid); end
    tick;                                    // N+1: in S1
    vec++;
    if ({out_valid, a, b} !== {1'b0, 5'h08, 5'h11}) begin
      errs++; $display("FAIL single_s1 got ov=%b a=%h b=%h want ov=0 a=08 b=11", out_valid, a, b);
    end
    tick;                                    // N+2: result
    vec++;
    if ({out_valid, out_sum, out_cout, out_zero} !== {1'b1, 5'h19, 1'b0, 1'b0}) begin
      errs++; $display("FAIL single_result got ov=%b sum=%h cout=%b zero=%b want 1 19 0 0",
                       out_valid, out_sum, out_cout, out_zero);
    end
    tick;
    vec++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL single_drain got %b want 0", out_valid); end
  endtask

  task automatic test_chain_fwd;
    out_ready = 1'b1;
    drive(1'b1, 4'h3, 5'h1F, 5'h01, 1'b0, 1'b0);
    tick;
    drive(1'b1, 4'h3, 5'h00, 5'h00, 1'b0, 1'b1);
    tick;
    drive(1'b0, 4'h0, 5'h00, 5'h00, 1'b0, 1'b0);
    tick;                                    // first result out, second in S1
    vec++;
    if ({out_valid, out_sum, out_cout, out_zero} !== {1'b1, 5'h00, 1'b1, 1'b1}) begin
      errs++; $display("FAIL chain_fwd_r0 got ov=%b sum=%h cout=%b zero=%b want 1 00 1 1",
                       out_valid, out_sum, out_cout, out_zero);
    end
    vec++;
    if (cin !== 1'b1) begin errs++; $display("FAIL chain_fwd_cin got %b want 1", cin); end
    tick;
    vec++;
    if ({out_valid, out_sum, out_cout, out_zero} !== {1'b1, 5'h01, 1'b0, 1'b0}) begin
      errs++; $display("FAIL chain_fwd_r1 got ov=%b sum=%h cout=%b zero=%b want 1 01 0 0",
                       out_valid, out_sum, out_cout, out_zero);
    end
    tick;
  endtask

  task automatic test_chain_carryq;
    out_ready = 1'b1;
    drive(1'b1, 4'h5, 5'h1F, 5'h01, 1'b0, 1'b0);
    tick;                                    // N
    drive(1'b0, 4'h0, 5'h00, 5'h00, 1'b0, 1'b0);
    tick;                                    // N+1 idle
    tick;                                    // N+2 idle, r0 result
    vec++;
    if ({out_valid, out_sum, out_cout, out_zero} !== {1'b1, 5'h00, 1'b1, 1'b1}) begin
      errs++; $display("FAIL chain_q_r0 got ov=%b sum=%h cout=%b zero=%b want 1 00 1 1",
                       out_valid, out_sum, out_cout, out_zero);
    end
    tick;                                    // N+3 idle
    drive(1'b1, 4'h5, 5'h00, 5'h00, 1'b0, 1'b1);
    tick;                                    // N+4 accepted
    drive(1'b0, 4'h0, 5'h00, 5'h00, 1'b0, 1'b0);
    tick;                                    // N+5 in S1 with carry from register
    vec++;
    if (cin !== 1'b1) begin errs++; $display("FAIL chain_q_cin got %b want 1", cin); end
    tick;
    vec++;
    if ({out_valid, out_sum, out_cout, out_zero} !== {1'b1, 5'h01, 1'b0, 1'b0}) begin
      errs++; $display("FAIL chain_q_r1 got ov=%b sum=%h cout=%b zero=%b want 1 01 0 0",
                       out_valid, out_sum, out_cout, out_zero);
    end
    tick;
  endtask

  task automatic test_backpressure;
    int  k;
    logic rdy;
    k = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'h1, 5'(k + 1), 5'h02, 1'b0, 1'b0);
      rdy = in_ready;
      tick;
      if (rdy) k++;
    end
    drive(1'b0, 4'h0, 5'h00, 5'h00, 1'b0, 1'b0);
    vec++;
    if (k !== 4) begin errs++; $display("FAIL bp_accepted got %0d want 4", k); end
    vec++;
    if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    vec++;
    if ({out_valid, out_sum, a} !== {1'b1, 5'h03, 5'h02}) begin
      errs++; $display("FAIL bp_hold0 got ov=%b sum=%h a=%h want 1 03 02", out_valid, out_sum, a);
    end
    tick; tick;
    vec++;
    if ({out_valid, out_sum, out_cout, a, b} !== {1'b1, 5'h03, 1'b0, 5'h02, 5'h02}) begin
      errs++; $display("FAIL bp_stable got ov=%b sum=%h cout=%b a=%h b=%h want 1 03 0 02 02",
                       out_valid, out_sum, out_cout, a, b);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      vec++;
      if ({out_valid, out_sum} !== {1'b1, 5'(j + 3)}) begin
        errs++; $display("FAIL bp_drain%0d got ov=%b sum=%h want 1 %h", j, out_valid, out_sum, 5'(j + 3));
      end
      tick;
    end
    vec++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'h2, 5'h1F, 5'h01, 1'b0, 1'b0);
      tick;
    end
    drive(1'b0, 4'h0, 5'h00, 5'h00, 1'b0, 1'b0);
    rst = 1'b1;
    tick;
    vec++;
    if ({mux_select, a, b, cin, out_valid, out_sum, out_cout, out_zero, in_ready} !==
        {4'h0, 5'h00, 5'h00, 1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL midrst_outputs got sel=%h a=%h b=%h cin=%b ov=%b sum=%h cout=%b zero=%b rdy=%b",
               mux_select, a, b, cin, out_valid, out_sum, out_cout, out_zero, in_ready);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      vec++;
      if (out_valid !== 1'b0) begin errs++; $display("FAIL midrst_stale%0d got ov=%b want 0", i, out_valid); end
    end
    drive(1'b1, 4'h0, 5'h03, 5'h04, 1'b1, 1'b1);
    tick;
    drive(1'b0, 4'h0, 5'h00, 5'h00, 1'b0, 1'b0);
    tick;
    vec++;
    if (cin !== 1'b0) begin errs++; $display("FAIL midrst_chain_cin got %b want 0", cin); end
    tick;
    vec++;
    if ({out_valid, out_sum, out_cout, out_zero} !== {1'b1, 5'h07, 1'b0, 1'b0}) begin
      errs++; $display("FAIL midrst_chain_res got ov=%b sum=%h cout=%b zero=%b want 1 07 0 0",
                       out_valid, out_sum, out_cout, out_zero);
    end
    tick;
  endtask

  task automatic test_random;
    localparam int N = 10000;
    logic [5:0] exp_q[$];
    logic [5:0] res, e;
    logic [4:0] ra, rb;
    logic       rc, rch, mc, v, in_fire, out_fire;
    logic [6:0] obs;
    int sent, got, cycles;
    sent = 0; got = 0; cycles = 0; mc = 1'b0;
    rst = 1'b1; tick; rst = 1'b0;
    while ((sent < N || exp_q.size() != 0) && cycles < 60000) begin
      v   = (sent < N) && ($urandom_range(0, 9) < 7);
      ra  = 5'($urandom); rb = 5'($urandom);
      rc  = 1'($urandom); rch = 1'($urandom);
      drive(v, 4'($urandom), ra, rb, rc, rch);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      obs      = {out_sum, out_cout, out_zero};
      if (out_fire) begin
        vec++;
        if (exp_q.size() == 0) begin
          errs++; $display("FAIL rand_unexpected got sum=%h cout=%b with empty scoreboard", out_sum, out_cout);
        end else begin
          e = exp_q.pop_front();
          got++;
          if (obs !== {e[4:0], e[5], (e[4:0] == 5'h00)}) begin
            errs++; $display("FAIL rand_result#%0d got sum=%h cout=%b zero=%b want sum=%h cout=%b",
                             got, out_sum, out_cout, out_zero, e[4:0], e[5]);
          end
        end
      end
      if (in_fire) begin
        res = {1'b0, ra} + {1'b0, rb} + {5'd0, (rch ? mc : rc)};
        mc  = res[5];
        exp_q.push_back(res);
        sent++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    drive(1'b0, 4'h0, 5'h00, 5'h00, 1'b0, 1'b0);
    vec++;
    if (got != N) begin errs++; $display("FAIL rand_count got %0d results want %0d (cycles %0d)", got, N, cycles); end
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    in_valid = 1'b0; in_op = 4'h0; in_a = 5'h0; in_b = 5'h0; in_cin = 1'b0; in_chain = 1'b0;
    test_reset;
    test_single;
    test_chain_fwd;
    test_chain_carryq;
    test_backpressure;
    test_reset_midstream;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
